// File: rtl/tetris_pkg.sv
// Shared types and constants for the Tetris board renderer: colour index, RGB struct, palette.
`timescale 1ns/1ps
package tetris_pkg;

  typedef logic [2:0] color_idx_t;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } rgb_t;

  localparam rgb_t PALETTE [8] = '{
    '{8'h00, 8'h00, 8'h00},
    '{8'h00, 8'hFF, 8'hFF},
    '{8'hFF, 8'hFF, 8'h00},
    '{8'h80, 8'h00, 8'h80},
    '{8'h00, 8'hFF, 8'h00},
    '{8'hFF, 8'h00, 8'h00},
    '{8'h00, 8'h00, 8'hFF},
    '{8'hFF, 8'h80, 8'h00}
  };

  localparam rgb_t BG_RGB     = '{8'h10, 8'h10, 8'h10};
  localparam rgb_t BORDER_RGB = '{8'h80, 8'h80, 8'h80};

  localparam logic [9:0] H_ACTIVE = 10'd640;
  localparam logic [9:0] V_ACTIVE = 10'd480;

endpackage

// File: rtl/tetris_board_ram.sv
// Playfield storage: simple dual-port RAM, one write port, one registered read port.
// A same-address read/write returns the old contents.
`timescale 1ns/1ps
module tetris_board_ram
  import tetris_pkg::*;
#(
  parameter int unsigned DEPTH = 200,
  parameter int unsigned AW    = 8
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  color_idx_t    wdata,
  input  logic [AW-1:0] raddr,
  output color_idx_t    rdata
);

  color_idx_t mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
    rdata <= mem[raddr];
  end

endmodule

// File: rtl/tetris_board_renderer.sv
// Renders the 10x20 Tetris playfield with a border from VGA pixel coordinates.
// Fixed 3-cycle latency; board writes accepted only in vertical blank.
`timescale 1ns/1ps
module tetris_board_renderer
  import tetris_pkg::*;
#(
  parameter int unsigned CELL_PX   = 16,
  parameter int unsigned BOARD_W   = 10,
  parameter int unsigned BOARD_H   = 20,
  parameter int unsigned ORG_X     = 240,
  parameter int unsigned ORG_Y     = 80,
  parameter int unsigned BORDER_PX = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [9:0] pix_x,
  input  logic [9:0] pix_y,
  input  logic       video_on,
  input  logic       hs_in,
  input  logic       vs_in,
  input  logic       wr_valid,
  output logic       wr_ready,
  input  logic [3:0] wr_col,
  input  logic [4:0] wr_row,
  input  logic [2:0] wr_color,
  input  logic       clear_req,
  output logic       busy,
  output logic       vga_HS,
  output logic       vga_VS,
  output logic [7:0] R,
  output logic [7:0] G,
  output logic [7:0] B
);

  localparam int unsigned      CellShift  = $clog2(CELL_PX);
  localparam logic [7:0]       LastAddr   = 8'(BOARD_W * BOARD_H - 1);
  localparam logic [3:0]       BoardWCols = 4'(BOARD_W);
  localparam logic [4:0]       BoardHRows = 5'(BOARD_H);
  localparam logic signed [10:0] OrgX     = 11'(ORG_X);
  localparam logic signed [10:0] OrgY     = 11'(ORG_Y);
  localparam logic signed [10:0] BoardWPx = 11'(BOARD_W * CELL_PX);
  localparam logic signed [10:0] BoardHPx = 11'(BOARD_H * CELL_PX);
  localparam logic signed [10:0] BorderPx = 11'(BORDER_PX);

  typedef enum logic [0:0] {StIdle, StClear} state_e;

  state_e     state_q, state_d;
  logic [7:0] sweep_q, sweep_d;

  logic       ram_we;
  logic [7:0] ram_waddr;
  color_idx_t ram_wdata;
  color_idx_t ram_rdata;

  assign busy     = (state_q == StClear);
  assign wr_ready = (state_q == StIdle) && !clear_req && (pix_y >= V_ACTIVE);

  // Out-of-range writes still handshake but never reach the RAM.
  logic wr_in_range;
  assign wr_in_range = (wr_col < BoardWCols) && (wr_row < BoardHRows);

  always_comb begin
    state_d   = state_q;
    sweep_d   = sweep_q;
    ram_we    = 1'b0;
    ram_waddr = 8'(wr_row * BOARD_W + wr_col);
    ram_wdata = wr_color;
    unique case (state_q)
      StClear: begin
        ram_we    = 1'b1;
        ram_waddr = sweep_q;
        ram_wdata = '0;
        if (sweep_q == LastAddr) begin
          state_d = StIdle;
          sweep_d = '0;
        end else begin
          sweep_d = sweep_q + 8'd1;
        end
      end
      StIdle: begin
        if (clear_req) begin
          state_d = StClear;
          sweep_d = '0;
        end else begin
          ram_we = wr_valid && wr_ready && wr_in_range;
        end
      end
      default: state_d = StClear;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StClear;
      sweep_q <= '0;
    end else begin
      state_q <= state_d;
      sweep_q <= sweep_d;
    end
  end

  // S1: board-relative coordinates, region flags and cell address.
  logic signed [10:0] dx, dy;
  logic [10:0]        col_s1, row_s1;
  logic               board_s1, border_s1;
  logic [7:0]         addr_s1;

  assign dx = $signed({1'b0, pix_x}) - OrgX;
  assign dy = $signed({1'b0, pix_y}) - OrgY;

  assign board_s1  = (dx >= 11'sd0) && (dx < BoardWPx) && (dy >= 11'sd0) && (dy < BoardHPx);
  assign border_s1 = !board_s1
                     && (dx >= -BorderPx) && (dx < BoardWPx + BorderPx)
                     && (dy >= -BorderPx) && (dy < BoardHPx + BorderPx);

  assign col_s1  = $unsigned(dx) >> CellShift;
  assign row_s1  = $unsigned(dy) >> CellShift;
  assign addr_s1 = board_s1 ? 8'(row_s1 * BOARD_W + col_s1) : 8'd0;

  logic [7:0]           addr1_q;
  logic                 board1_q, border1_q, board2_q, border2_q, clear2_q;
  logic [CellShift-1:0] offx1_q, offy1_q, offx2_q, offy2_q;
  logic [2:0]           hs_q, vs_q, vo_q;
  rgb_t                 rgb_d, rgb_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr1_q   <= '0;
      board1_q  <= 1'b0;
      border1_q <= 1'b0;
      offx1_q   <= '0;
      offy1_q   <= '0;
      board2_q  <= 1'b0;
      border2_q <= 1'b0;
      clear2_q  <= 1'b1;
      offx2_q   <= '0;
      offy2_q   <= '0;
      rgb_q     <= '0;
      hs_q      <= '1;
      vs_q      <= '1;
      vo_q      <= '0;
    end else begin
      addr1_q   <= addr_s1;
      board1_q  <= board_s1;
      border1_q <= border_s1;
      offx1_q   <= dx[CellShift-1:0];
      offy1_q   <= dy[CellShift-1:0];
      board2_q  <= board1_q;
      border2_q <= border1_q;
      clear2_q  <= (state_q == StClear);
      offx2_q   <= offx1_q;
      offy2_q   <= offy1_q;
      rgb_q     <= rgb_d;
      hs_q      <= {hs_q[1:0], hs_in};
      vs_q      <= {vs_q[1:0], vs_in};
      vo_q      <= {vo_q[1:0], video_on};
    end
  end

  tetris_board_ram #(
    .DEPTH (BOARD_W * BOARD_H),
    .AW    (8)
  ) u_ram (
    .clk   (clk),
    .we    (ram_we),
    .waddr (ram_waddr),
    .wdata (ram_wdata),
    .raddr (addr1_q),
    .rdata (ram_rdata)
  );

  // S3: a sweep in progress hides stale RAM contents by forcing empty cells.
  color_idx_t idx_s2;
  assign idx_s2 = clear2_q ? color_idx_t'(0) : ram_rdata;

  always_comb begin
    rgb_d = '0;
    if (border2_q) begin
      rgb_d = BORDER_RGB;
    end else if (board2_q) begin
      if (idx_s2 == '0) begin
        rgb_d = BG_RGB;
      end else if (!(&offx2_q) && !(&offy2_q)) begin
        rgb_d = PALETTE[idx_s2];
      end
    end
  end

  assign vga_HS = hs_q[2];
  assign vga_VS = vs_q[2];
  assign R      = vo_q[2] ? rgb_q.r : 8'd0;
  assign G      = vo_q[2] ? rgb_q.g : 8'd0;
  assign B      = vo_q[2] ? rgb_q.b : 8'd0;

endmodule

// File: tb/tb_tetris_board_renderer.sv
// Directed, table-driven bench for tetris_board_renderer with a cell model of the board.
`timescale 1ns/1ps
module tb_tetris_board_renderer;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [9:0] pix_x, pix_y;
  logic       video_on, hs_in, vs_in;
  logic       wr_valid, wr_ready;
  logic [3:0] wr_col;
  logic [4:0] wr_row;
  logic [2:0] wr_color;
  logic       clear_req, busy;
  logic       vga_HS, vga_VS;
  logic [7:0] R, G, B;

  always #5 clk = ~clk;

  tetris_board_renderer dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .pix_x     (pix_x),
    .pix_y     (pix_y),
    .video_on  (video_on),
    .hs_in     (hs_in),
    .vs_in     (vs_in),
    .wr_valid  (wr_valid),
    .wr_ready  (wr_ready),
    .wr_col    (wr_col),
    .wr_row    (wr_row),
    .wr_color  (wr_color),
    .clear_req (clear_req),
    .busy      (busy),
    .vga_HS    (vga_HS),
    .vga_VS    (vga_VS),
    .R         (R),
    .G         (G),
    .B         (B)
  );

  typedef struct {
    logic [9:0]  x;
    logic [9:0]  y;
    logic        vo;
    logic [23:0] rgb;
  } vec_t;

  localparam logic [23:0] Bg     = 24'h101010;
  localparam logic [23:0] Border = 24'h808080;

  int          tests = 0;
  int          fails = 0;
  logic [2:0]  model [200];
  logic [23:0] pal   [8];
  vec_t        vecs  [16];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Call just after a negedge; returns just after a negedge.
  task automatic render(input logic [9:0] x, input logic [9:0] y, input logic vo,
                        input logic [23:0] exp, input string name);
    pix_x    = x;
    pix_y    = y;
    video_on = vo;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk(name, 32'({R, G, B}), 32'(exp));
  endtask

  task automatic do_write(input logic [3:0] c, input logic [4:0] r, input logic [2:0] color,
                          input string name);
    pix_y    = 10'd490;
    wr_col   = c;
    wr_row   = r;
    wr_color = color;
    wr_valid = 1'b1;
    #1;
    chk(name, 32'(wr_ready), 32'd1);
    @(posedge clk);
    @(negedge clk);
    wr_valid = 1'b0;
    if (c < 4'd10 && r < 5'd20) model[int'(r) * 10 + int'(c)] = color;
  endtask

  task automatic readback(input string tag);
    for (int r = 0; r < 20; r++) begin
      for (int c = 0; c < 10; c++) begin
        render(10'(240 + c * 16 + 8), 10'(80 + r * 16 + 8), 1'b1,
               (model[r * 10 + c] == 3'd0) ? Bg : pal[model[r * 10 + c]],
               $sformatf("%s_r%0dc%0d", tag, r, c));
      end
    end
    pix_y = 10'd490;
  endtask

  // Counts negedges with busy high, starting at the current one.
  task automatic count_busy(output int cnt, output logic rdy_seen);
    cnt      = 0;
    rdy_seen = 1'b0;
    while (busy && cnt < 300) begin
      cnt++;
      if (wr_ready) rdy_seen = 1'b1;
      @(negedge clk);
    end
  endtask

  initial begin
    int   cnt;
    logic rdy_seen;

    pal[0] = 24'h000000; pal[1] = 24'h00FFFF; pal[2] = 24'hFFFF00; pal[3] = 24'h800080;
    pal[4] = 24'h00FF00; pal[5] = 24'hFF0000; pal[6] = 24'h0000FF; pal[7] = 24'hFF8000;
    for (int i = 0; i < 200; i++) model[i] = 3'd0;

    // Expectations assume cell (3,5) holds colour 5 and every other cell is empty.
    vecs[0]  = '{10'd290, 10'd165, 1'b1, 24'hFF0000};
    vecs[1]  = '{10'd303, 10'd165, 1'b1, 24'h000000};
    vecs[2]  = '{10'd290, 10'd175, 1'b1, 24'h000000};
    vecs[3]  = '{10'd304, 10'd165, 1'b1, Bg};
    vecs[4]  = '{10'd290, 10'd165, 1'b0, 24'h000000};
    vecs[5]  = '{10'd238, 10'd200, 1'b1, Border};
    vecs[6]  = '{10'd650, 10'd200, 1'b1, 24'h000000};
    vecs[7]  = '{10'd236, 10'd200, 1'b1, Border};
    vecs[8]  = '{10'd235, 10'd200, 1'b1, 24'h000000};
    vecs[9]  = '{10'd399, 10'd200, 1'b1, Bg};
    vecs[10] = '{10'd400, 10'd200, 1'b1, Border};
    vecs[11] = '{10'd403, 10'd76,  1'b1, Border};
    vecs[12] = '{10'd404, 10'd76,  1'b1, 24'h000000};
    vecs[13] = '{10'd244, 10'd400, 1'b1, Border};
    vecs[14] = '{10'd244, 10'd404, 1'b1, 24'h000000};
    vecs[15] = '{10'd288, 10'd160, 1'b1, 24'hFF0000};

    rst_n = 1'b0; pix_x = 10'd0; pix_y = 10'd490; video_on = 1'b1;
    hs_in = 1'b1; vs_in = 1'b1; wr_valid = 1'b0; wr_col = 4'd0; wr_row = 5'd0;
    wr_color = 3'd0; clear_req = 1'b0;

    repeat (3) @(negedge clk);
    chk("rst_busy", 32'(busy), 32'd1);
    chk("rst_ready", 32'(wr_ready), 32'd0);
    chk("rst_hs", 32'(vga_HS), 32'd1);
    chk("rst_vs", 32'(vga_VS), 32'd1);
    chk("rst_rgb", 32'({R, G, B}), 32'd0);

    rst_n = 1'b1;
    count_busy(cnt, rdy_seen);
    chk("init_sweep_len", 32'(cnt), 32'd200);
    chk("ready_while_busy", 32'(rdy_seen), 32'd0);
    pix_y = 10'd479; #1;
    chk("ready_y479", 32'(wr_ready), 32'd0);
    pix_y = 10'd480; #1;
    chk("ready_y480", 32'(wr_ready), 32'd1);
    @(negedge clk);
    readback("empty");

    hs_in = 1'b0; vs_in = 1'b0;
    @(posedge clk); @(posedge clk); @(negedge clk);
    chk("hs_t2", 32'(vga_HS), 32'd1);
    @(posedge clk); @(negedge clk);
    chk("hs_t3", 32'(vga_HS), 32'd0);
    chk("vs_t3", 32'(vga_VS), 32'd0);
    hs_in = 1'b1; vs_in = 1'b1;
    repeat (3) @(negedge clk);
    chk("hs_back", 32'(vga_HS), 32'd1);

    do_write(4'd3, 5'd5, 3'd5, "wr_3_5");
    for (int i = 0; i < 16; i++) begin
      render(vecs[i].x, vecs[i].y, vecs[i].vo, vecs[i].rgb, $sformatf("vec%0d", i));
    end
    video_on = 1'b1;

    // Write held off by active video, then accepted once vblank starts.
    pix_x = 10'd245; pix_y = 10'd85;
    wr_col = 4'd0; wr_row = 5'd0; wr_color = 3'd2; wr_valid = 1'b1;
    #1;
    chk("pend_not_ready", 32'(wr_ready), 32'd0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("pend_unchanged", 32'({R, G, B}), 32'(Bg));
    pix_y = 10'd480; #1;
    chk("pend_ready", 32'(wr_ready), 32'd1);
    @(posedge clk); @(negedge clk);
    wr_valid = 1'b0;
    model[0] = 3'd2;
    render(10'd245, 10'd85, 1'b1, pal[2], "pend_done");

    do_write(4'd12, 5'd2, 3'd7, "oob_col12");
    do_write(4'd10, 5'd0, 3'd6, "oob_col10");
    readback("oob");

    // Clear and write in the same cycle: clear wins.
    pix_y = 10'd490; wr_col = 4'd1; wr_row = 5'd1; wr_color = 3'd3;
    wr_valid = 1'b1; clear_req = 1'b1;
    #1;
    chk("clr_blocks_wr", 32'(wr_ready), 32'd0);
    @(posedge clk); @(negedge clk);
    clear_req = 1'b0; wr_valid = 1'b0;
    chk("clr_busy_rise", 32'(busy), 32'd1);
    pix_x = 10'd290; pix_y = 10'd165;
    cnt = 0;
    while (busy && cnt < 300) begin
      cnt++;
      if (cnt == 4) chk("clr_forced_bg", 32'({R, G, B}), 32'(Bg));
      if (cnt == 100) clear_req = 1'b1;
      if (cnt == 101) clear_req = 1'b0;
      @(negedge clk);
    end
    clear_req = 1'b0;
    chk("clr_sweep_len", 32'(cnt), 32'd200);
    for (int i = 0; i < 200; i++) model[i] = 3'd0;
    readback("cleared");

    // Reset in the middle of a sweep.
    clear_req = 1'b1;
    @(posedge clk); @(negedge clk);
    clear_req = 1'b0;
    repeat (50) @(negedge clk);
    pix_x = 10'd290; pix_y = 10'd165; hs_in = 1'b0; vs_in = 1'b0;
    repeat (4) @(negedge clk);
    chk("mid_rgb", 32'({R, G, B}), 32'(Bg));
    chk("mid_hs", 32'(vga_HS), 32'd0);
    rst_n = 1'b0; #1;
    chk("mid_rst_rgb", 32'({R, G, B}), 32'd0);
    chk("mid_rst_hs", 32'(vga_HS), 32'd1);
    chk("mid_rst_vs", 32'(vga_VS), 32'd1);
    chk("mid_rst_busy", 32'(busy), 32'd1);
    hs_in = 1'b1; vs_in = 1'b1; pix_y = 10'd490;
    @(negedge clk);
    rst_n = 1'b1;
    count_busy(cnt, rdy_seen);
    chk("rst_sweep_len", 32'(cnt), 32'd200);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
